// File: rtl/insn_fetch_unit.sv
// ---------------------------------------------------------------------------
// insn_fetch_unit
//
// Fetch stage sitting behind the next-PC generator. It latches a fetch
// address, issues one instruction-memory read at a time, pulses o_fetch_en so
// the generator advances, and buffers returned words (with their PC) in a
// small FIFO that decode drains through a valid/ready handshake. A flush
// redirects the fetch address and throws away buffered and in-flight work.
//
// Optional feature macro: FETCH_BUF_BYPASS_EN
//   defined   : when the FIFO is empty, a response is presented on o_insn*
//               in the same cycle; if decode takes it, it is never written.
//   undefined : every response is written; o_insn_valid rises one cycle
//               after i_imem_rsp_valid.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_next_pc_valid     i_next_pc carries a new fetch word address
//   i_next_pc           next word address from the PC generator
//   o_fetch_en          request accepted this cycle (generator advances)
//   o_fetch_pc          word address of the current/pending request
//   o_imem_req_valid    memory read request
//   o_imem_req_addr     request word address (always o_fetch_pc)
//   i_imem_req_ready    memory accepts the request
//   i_imem_rsp_valid    read data valid (in order, >=1 cycle after accept)
//   i_imem_rsp_data     read data
//   i_flush             redirect, discard all fetched/in-flight work
//   i_flush_pc          redirect word address
//   o_insn_valid        FIFO head valid
//   o_insn              FIFO head instruction
//   o_insn_pc           FIFO head PC
//   i_insn_ready        decode consumes the head when valid && ready
// ---------------------------------------------------------------------------
module insn_fetch_unit #(
  parameter int ADDR_WIDTH     = 16,
  parameter int INSN_SIZE_BITS = 2,
  parameter int INSN_WIDTH     = 32,
  parameter int BUF_DEPTH      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_next_pc_valid,
  input  logic [ADDR_WIDTH-INSN_SIZE_BITS-1:0] i_next_pc,
  output logic                                 o_fetch_en,
  output logic [ADDR_WIDTH-INSN_SIZE_BITS-1:0] o_fetch_pc,
  output logic                                 o_imem_req_valid,
  output logic [ADDR_WIDTH-INSN_SIZE_BITS-1:0] o_imem_req_addr,
  input  logic                                 i_imem_req_ready,
  input  logic                                 i_imem_rsp_valid,
  input  logic [INSN_WIDTH-1:0]                i_imem_rsp_data,
  input  logic                                 i_flush,
  input  logic [ADDR_WIDTH-INSN_SIZE_BITS-1:0] i_flush_pc,
  output logic                                 o_insn_valid,
  output logic [INSN_WIDTH-1:0]                o_insn,
  output logic [ADDR_WIDTH-INSN_SIZE_BITS-1:0] o_insn_pc,
  input  logic                                 i_insn_ready
);

  localparam int PW    = ADDR_WIDTH - INSN_SIZE_BITS;
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,   // no PC held
    S_REQ   = 2'd1,   // PC held, request pending
    S_WAIT  = 2'd2,   // one request in flight
    S_DRAIN = 2'd3    // in-flight response will be dropped
  } state_t;

  state_t                r_state;
  logic [PW-1:0]         r_fetch_pc;
  logic [PW-1:0]         r_pend_pc;
  logic                  r_pc_vld;
  logic                  r_ign_npc;

  logic [INSN_WIDTH-1:0] r_buf_insn [BUF_DEPTH];
  logic [PW-1:0]         r_buf_pc   [BUF_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [PTR_W:0]        r_count;

  logic                  w_req_valid;
  logic                  w_accept;
  logic                  w_npc_ok;
  logic                  w_rsp_take;
  logic                  w_fifo_vld;
  logic                  w_push;
  logic                  w_pop;
`ifdef FETCH_BUF_BYPASS_EN
  logic                  w_byp;
`endif

  // Request gating, handshake decode and FIFO push/pop qualification
  always_comb begin
    // A request is only issued while a FIFO slot is free for its word, so
    // the in-flight response always has somewhere to land.
    w_req_valid = (r_state == S_REQ) && (r_count < DEPTH_C);
    w_accept    = w_req_valid && i_imem_req_ready;
    // The first next_pc_valid after a flush is the generator's stale
    // increment of the pre-flush address and must not be latched.
    w_npc_ok    = i_next_pc_valid && !r_ign_npc;
    w_rsp_take  = (r_state == S_WAIT) && i_imem_rsp_valid && !i_flush;
    w_fifo_vld  = (r_count != {(PTR_W+1){1'b0}});
    w_pop       = w_fifo_vld && i_insn_ready;
`ifdef FETCH_BUF_BYPASS_EN
    w_byp       = w_rsp_take && !w_fifo_vld;
    w_push      = w_rsp_take && !(w_byp && i_insn_ready);
`else
    w_push      = w_rsp_take;
`endif
  end

  // Output drive: handshake, address and FIFO head (optionally bypassed)
  always_comb begin
    o_fetch_en       = w_accept;
    o_imem_req_valid = w_req_valid;
    o_imem_req_addr  = r_fetch_pc;
    o_fetch_pc       = r_fetch_pc;
    o_insn_valid     = w_fifo_vld;
    o_insn           = r_buf_insn[r_rptr];
    o_insn_pc        = r_buf_pc[r_rptr];
`ifdef FETCH_BUF_BYPASS_EN
    if (w_byp) begin
      o_insn_valid = 1'b1;
      o_insn       = i_imem_rsp_data;
      o_insn_pc    = r_fetch_pc;
    end else begin
      o_insn_valid = w_fifo_vld;
    end
`endif
  end

  // Fetch FSM: fetch address, pending next PC and flush redirection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= {PW{1'b0}};
      r_pend_pc  <= {PW{1'b0}};
      r_pc_vld   <= 1'b0;
      r_ign_npc  <= 1'b0;
    end else if (i_flush) begin
      r_fetch_pc <= i_flush_pc;
      r_pc_vld   <= 1'b0;
      r_ign_npc  <= 1'b1;
      case (r_state)
        // A response arriving with the flush is the in-flight word itself,
        // so nothing is left to drain.
        S_WAIT:  r_state <= i_imem_rsp_valid ? S_REQ : S_DRAIN;
        S_DRAIN: r_state <= i_imem_rsp_valid ? S_REQ : S_DRAIN;
        // Flush in the accept cycle: the accepted read is now in flight.
        S_REQ:   r_state <= w_accept ? S_DRAIN : S_REQ;
        default: r_state <= S_REQ;
      endcase
    end else begin
      r_ign_npc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_npc_ok) begin
            r_fetch_pc <= i_next_pc;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_accept) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_rsp_valid) begin
            r_pc_vld <= 1'b0;
            if (w_npc_ok) begin
              r_fetch_pc <= i_next_pc;
              r_state    <= S_REQ;
            end else if (r_pc_vld) begin
              r_fetch_pc <= r_pend_pc;
              r_state    <= S_REQ;
            end else begin
              r_state    <= S_IDLE;
            end
          end else if (w_npc_ok) begin
            r_pend_pc <= i_next_pc;
            r_pc_vld  <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (i_imem_rsp_valid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; flush empties the buffer on the same edge
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {(PTR_W+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (w_push && !rst && !i_flush) begin
      r_buf_insn[r_wptr] <= i_imem_rsp_data;
      r_buf_pc[r_wptr]   <= r_fetch_pc;
    end
  end

endmodule

// File: tb/tb_insn_fetch_unit.sv
module tb_insn_fetch_unit;

  localparam int PW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_next_pc_valid;
  logic [PW-1:0] i_next_pc;
  logic          o_fetch_en;
  logic [PW-1:0] o_fetch_pc;
  logic          o_imem_req_valid;
  logic [PW-1:0] o_imem_req_addr;
  logic          i_imem_req_ready;
  logic          i_imem_rsp_valid;
  logic [31:0]   i_imem_rsp_data;
  logic          i_flush;
  logic [PW-1:0] i_flush_pc;
  logic          o_insn_valid;
  logic [31:0]   o_insn;
  logic [PW-1:0] o_insn_pc;
  logic          i_insn_ready;

  insn_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .i_next_pc_valid  (i_next_pc_valid),
    .i_next_pc        (i_next_pc),
    .o_fetch_en       (o_fetch_en),
    .o_fetch_pc       (o_fetch_pc),
    .o_imem_req_valid (o_imem_req_valid),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_req_ready (i_imem_req_ready),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_flush          (i_flush),
    .i_flush_pc       (i_flush_pc),
    .o_insn_valid     (o_insn_valid),
    .o_insn           (o_insn),
    .o_insn_pc        (o_insn_pc),
    .i_insn_ready     (i_insn_ready)
  );

  always #5 clk = ~clk;

  // One cycle: inputs applied, outputs expected (sampled mid-cycle).
  // Response data is 0xD000_0000 | word address so each word names its PC.
  typedef struct {
    logic          rst, npv;
    logic [PW-1:0] npc;
    logic          rdy, rsp;
    logic [PW-1:0] rda;
    logic          fl;
    logic [PW-1:0] fpc;
    logic          ir;
    logic          e_fe, e_rv;
    logic [PW-1:0] e_addr;
    logic          e_iv;
    logic [PW-1:0] e_ipc;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [31:0] word_of(input logic [PW-1:0] a);
    return 32'hD000_0000 | {18'd0, a};
  endfunction

  task automatic add(input logic rst_v, input logic npv, input logic [PW-1:0] npc,
                     input logic rdy, input logic rsp, input logic [PW-1:0] rda,
                     input logic fl, input logic [PW-1:0] fpc, input logic ir,
                     input logic e_fe, input logic e_rv, input logic [PW-1:0] e_addr,
                     input logic e_iv, input logic [PW-1:0] e_ipc);
    vec_t v;
    v.rst = rst_v; v.npv = npv; v.npc = npc; v.rdy = rdy; v.rsp = rsp; v.rda = rda;
    v.fl = fl; v.fpc = fpc; v.ir = ir; v.e_fe = e_fe; v.e_rv = e_rv;
    v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; i_next_pc_valid = 1'b0; i_next_pc = '0; i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0; i_imem_rsp_data = '0; i_flush = 1'b0; i_flush_pc = '0;
    i_insn_ready = 1'b0;
  endtask

  initial begin
    bit found;
    //   rst npv npc     rdy rsp rda     fl fpc     ir   fe rv addr    iv ipc
    // reset, then first fetch of 0x100
    add(1, 0, 14'h000, 0, 0, 14'h000, 0, 14'h000, 0,   0, 0, 14'h000, 0, 14'h000);
    add(1, 0, 14'h000, 0, 0, 14'h000, 0, 14'h000, 0,   0, 0, 14'h000, 0, 14'h000);
    add(1, 0, 14'h000, 0, 0, 14'h000, 0, 14'h000, 0,   0, 0, 14'h000, 0, 14'h000);
    add(0, 1, 14'h100, 0, 0, 14'h000, 0, 14'h000, 0,   0, 0, 14'h000, 0, 14'h000);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 1,   1, 1, 14'h100, 0, 14'h000);
    // streaming, 1-cycle memory, decode always ready
    add(0, 1, 14'h101, 0, 1, 14'h100, 0, 14'h000, 1,   0, 0, 14'h000, 0, 14'h000);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 1,   1, 1, 14'h101, 1, 14'h100);
    add(0, 1, 14'h102, 0, 1, 14'h101, 0, 14'h000, 1,   0, 0, 14'h000, 0, 14'h000);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 1,   1, 1, 14'h102, 1, 14'h101);
    add(0, 1, 14'h103, 0, 1, 14'h102, 0, 14'h000, 1,   0, 0, 14'h000, 0, 14'h000);
    // backpressure: fill to 4, requests stop until a pop
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 0,   1, 1, 14'h103, 1, 14'h102);
    add(0, 1, 14'h104, 0, 1, 14'h103, 0, 14'h000, 0,   0, 0, 14'h000, 1, 14'h102);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 0,   1, 1, 14'h104, 1, 14'h102);
    add(0, 1, 14'h105, 0, 1, 14'h104, 0, 14'h000, 0,   0, 0, 14'h000, 1, 14'h102);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 0,   1, 1, 14'h105, 1, 14'h102);
    add(0, 1, 14'h106, 0, 1, 14'h105, 0, 14'h000, 0,   0, 0, 14'h000, 1, 14'h102);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 0,   0, 0, 14'h000, 1, 14'h102);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 0,   0, 0, 14'h000, 1, 14'h102);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 1,   0, 0, 14'h000, 1, 14'h102);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 0,   1, 1, 14'h106, 1, 14'h103);
    // push and pop in the same cycle keeps order
    add(0, 1, 14'h107, 0, 1, 14'h106, 0, 14'h000, 1,   0, 0, 14'h000, 1, 14'h103);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 0,   1, 1, 14'h107, 1, 14'h104);
    add(0, 1, 14'h108, 0, 1, 14'h107, 0, 14'h000, 0,   0, 0, 14'h000, 1, 14'h104);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 1,   0, 0, 14'h000, 1, 14'h104);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 0,   1, 1, 14'h108, 1, 14'h105);
    add(0, 1, 14'h109, 0, 0, 14'h000, 0, 14'h000, 1,   0, 0, 14'h000, 1, 14'h105);
    // flush while waiting: stale response and stale next_pc dropped
    add(0, 0, 14'h000, 0, 0, 14'h000, 1, 14'h200, 0,   0, 0, 14'h000, 1, 14'h106);
    add(0, 1, 14'h10A, 0, 0, 14'h000, 0, 14'h000, 0,   0, 0, 14'h000, 0, 14'h000);
    add(0, 0, 14'h000, 0, 1, 14'h108, 0, 14'h000, 0,   0, 0, 14'h000, 0, 14'h000);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 1,   1, 1, 14'h200, 0, 14'h000);
    add(0, 1, 14'h201, 0, 1, 14'h200, 0, 14'h000, 1,   0, 0, 14'h000, 0, 14'h000);
    add(0, 0, 14'h000, 0, 0, 14'h000, 0, 14'h000, 1,   0, 1, 14'h201, 1, 14'h200);
    // flush in the accept cycle
    add(0, 0, 14'h000, 1, 0, 14'h000, 1, 14'h300, 1,   1, 1, 14'h201, 0, 14'h000);
    add(0, 1, 14'h202, 0, 1, 14'h201, 0, 14'h000, 1,   0, 0, 14'h000, 0, 14'h000);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 1,   1, 1, 14'h300, 0, 14'h000);
    add(0, 1, 14'h301, 0, 1, 14'h300, 0, 14'h000, 0,   0, 0, 14'h000, 0, 14'h000);
    add(0, 0, 14'h000, 0, 0, 14'h000, 0, 14'h000, 0,   0, 1, 14'h301, 1, 14'h300);
    // flush while a request is pending, with a buffered word
    add(0, 0, 14'h000, 0, 0, 14'h000, 1, 14'h040, 0,   0, 1, 14'h301, 1, 14'h300);
    add(0, 1, 14'h302, 0, 0, 14'h000, 0, 14'h000, 0,   0, 1, 14'h040, 0, 14'h000);
    add(0, 0, 14'h000, 1, 0, 14'h000, 0, 14'h000, 0,   1, 1, 14'h040, 0, 14'h000);
    add(0, 0, 14'h000, 0, 1, 14'h040, 0, 14'h000, 0,   0, 0, 14'h000, 0, 14'h000);
    add(0, 0, 14'h000, 0, 0, 14'h000, 0, 14'h000, 0,   0, 0, 14'h000, 1, 14'h040);
    // reset mid-operation, late response ignored
    add(1, 0, 14'h000, 0, 0, 14'h000, 0, 14'h000, 0,   0, 0, 14'h000, 1, 14'h040);
    add(0, 0, 14'h000, 0, 1, 14'h999, 0, 14'h000, 0,   0, 0, 14'h000, 0, 14'h000);
    add(0, 0, 14'h000, 0, 0, 14'h000, 0, 14'h000, 0,   0, 0, 14'h000, 0, 14'h000);

    idle_inputs();
    rst = 1'b1;
    @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      rst              = vq[i].rst;
      i_next_pc_valid  = vq[i].npv;
      i_next_pc        = vq[i].npc;
      i_imem_req_ready = vq[i].rdy;
      i_imem_rsp_valid = vq[i].rsp;
      i_imem_rsp_data  = vq[i].rsp ? word_of(vq[i].rda) : 32'h0;
      i_flush          = vq[i].fl;
      i_flush_pc       = vq[i].fpc;
      i_insn_ready     = vq[i].ir;
      @(negedge clk);
      chk($sformatf("v%0d_fetch_en", i), {31'd0, o_fetch_en}, {31'd0, vq[i].e_fe});
      chk($sformatf("v%0d_req_valid", i), {31'd0, o_imem_req_valid}, {31'd0, vq[i].e_rv});
      if (vq[i].e_rv) begin
        chk($sformatf("v%0d_req_addr", i), {18'd0, o_imem_req_addr}, {18'd0, vq[i].e_addr});
        chk($sformatf("v%0d_fetch_pc", i), {18'd0, o_fetch_pc}, {18'd0, vq[i].e_addr});
      end
      chk($sformatf("v%0d_insn_valid", i), {31'd0, o_insn_valid}, {31'd0, vq[i].e_iv});
      if (vq[i].e_iv) begin
        chk($sformatf("v%0d_insn_pc", i), {18'd0, o_insn_pc}, {18'd0, vq[i].e_ipc});
        chk($sformatf("v%0d_insn", i), o_insn, word_of(vq[i].e_ipc));
      end
    end

    // Slow memory: next_pc arrives while waiting and is held as pending PC
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; i_next_pc_valid = 1'b1; i_next_pc = 14'h010;
    @(posedge clk); #1;
    i_next_pc_valid = 1'b0; i_imem_req_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_imem_req_valid) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("hs_req_seen", {31'd0, found}, 32'd1);
    chk("hs_req_addr", {18'd0, o_imem_req_addr}, 32'h010);
    chk("hs_fetch_en", {31'd0, o_fetch_en}, 32'd1);
    @(posedge clk); #1;
    i_imem_req_ready = 1'b0; i_next_pc_valid = 1'b1; i_next_pc = 14'h011;
    @(posedge clk); #1;
    i_next_pc_valid = 1'b0;
    @(posedge clk); #1;
    i_imem_rsp_valid = 1'b1; i_imem_rsp_data = word_of(14'h010);
    @(negedge clk);
`ifdef FETCH_BUF_BYPASS_EN
    chk("hs_bypass_valid", {31'd0, o_insn_valid}, 32'd1);
    chk("hs_bypass_pc", {18'd0, o_insn_pc}, 32'h010);
`else
    chk("hs_rsp_cycle_valid", {31'd0, o_insn_valid}, 32'd0);
`endif
    @(posedge clk); #1;
    i_imem_rsp_valid = 1'b0; i_imem_rsp_data = 32'h0;
    @(negedge clk);
    chk("hs_insn_valid", {31'd0, o_insn_valid}, 32'd1);
    chk("hs_insn_pc", {18'd0, o_insn_pc}, 32'h010);
    chk("hs_insn", o_insn, word_of(14'h010));
    chk("hs_pend_req_valid", {31'd0, o_imem_req_valid}, 32'd1);
    chk("hs_pend_req_addr", {18'd0, o_imem_req_addr}, 32'h011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
